// File: rtl/noun_loader_pkg.sv
// noun_loader_pkg: shared encodings for the noun loader front-end.
// Readback verification states exist only when NOUN_LOADER_READBACK_EN is defined.
package noun_loader_pkg;

    localparam int         NL_ADDR_W     = 10;
    localparam int         NL_DATA_W     = 64;
    localparam int         NL_MAX_ADDR   = 1023;
    localparam logic [1:0] NL_FUNC_WRITE = 2'b01;
    localparam logic [1:0] NL_FUNC_READ  = 2'b00;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVF      = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_WAIT_MEM,
        S_START,
        S_RUN,
        S_ERROR
`ifdef NOUN_LOADER_READBACK_EN
        ,
        S_VERIFY,
        S_VERIFY_WAIT
`endif
    } loader_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_MASK,
        REQ_WAIT
    } req_state_t;

endpackage

// File: rtl/noun_loader_mem_req_ctrl.sv
// mem_req_ctrl: issues a single-cycle memory strobe, ignores mem_ready while
// the memory is still reporting its pre-request ready, then reports completion.
module mem_req_ctrl
    import noun_loader_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_memReady,
    output logic o_strobe,
    output logic o_done
);

    req_state_t r_state;
    logic       r_strobe;
    logic       r_done;

    // Strobe one cycle, skip the stale ready during the strobe cycle, then wait for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= REQ_IDLE;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                REQ_IDLE: begin
                    if (i_start) begin
                        r_strobe <= 1'b1;
                        r_state  <= REQ_MASK;
                    end
                end
                REQ_MASK: begin
                    r_strobe <= 1'b0;
                    r_state  <= REQ_WAIT;
                end
                REQ_WAIT: begin
                    if (i_memReady) begin
                        r_done  <= 1'b1;
                        r_state <= REQ_IDLE;
                    end
                end
                default: r_state <= REQ_IDLE;
            endcase
        end
    end

    assign o_strobe = r_strobe;
    assign o_done   = r_done;

endmodule

// File: rtl/noun_loader.sv
// noun_loader: streams pre-encoded noun words into memory_unit, then launches
// mem_traversal at the root address and reports completion.
// Define NOUN_LOADER_READBACK_EN to re-read the image and check an XOR checksum
// before the traversal is started.
module noun_loader
    import noun_loader_pkg::*;
#(
    parameter int         ADDR_W     = NL_ADDR_W,
    parameter int         DATA_W     = NL_DATA_W,
    parameter int         MAX_ADDR   = NL_MAX_ADDR,
    parameter logic [1:0] FUNC_WRITE = NL_FUNC_WRITE,
    parameter logic [1:0] FUNC_READ  = NL_FUNC_READ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] root_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [1:0]        mem_func,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_owner,
    output logic [ADDR_W-1:0] trav_start_addr,
    output logic              trav_execute,
    input  logic              trav_finished,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    loader_state_t     r_state;
    logic [ADDR_W:0]   r_addr;
    logic [ADDR_W-1:0] r_rootAddr;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [1:0]        r_memFunc;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_busOwner;
    logic [ADDR_W-1:0] r_travStartAddr;
    logic              r_travExecute;
    logic [ADDR_W:0]   r_wordsLoaded;
    logic              r_done;
    logic [1:0]        r_err;

    logic              w_inReady;
    logic              w_overflow;
    logic              w_reqStart;
    logic              w_reqDone;
    logic              w_strobe;

`ifdef NOUN_LOADER_READBACK_EN
    logic [ADDR_W-1:0] r_baseAddr;
    logic [ADDR_W:0]   r_verifyAddr;
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_readSum;
`else
    logic              w_unusedRdata;
    assign w_unusedRdata = ^{mem_rdata, FUNC_READ};
`endif

    assign w_inReady  = (r_state == S_ACCEPT) && mem_ready;
    assign w_overflow = (r_addr > (ADDR_W + 1)'(MAX_ADDR));

`ifdef NOUN_LOADER_READBACK_EN
    assign w_reqStart = ((r_state == S_WRITE) && !w_overflow) ||
                        ((r_state == S_VERIFY) && (r_verifyAddr != r_addr));
`else
    assign w_reqStart = (r_state == S_WRITE) && !w_overflow;
`endif

    mem_req_ctrl u_memReq (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_reqStart),
        .i_memReady (mem_ready),
        .o_strobe   (w_strobe),
        .o_done     (w_reqDone)
    );

    // Main loader sequence: accept, write, wait, then launch and supervise the traversal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_rootAddr      <= '0;
            r_data          <= '0;
            r_last          <= 1'b0;
            r_memFunc       <= 2'b00;
            r_memAddr       <= '0;
            r_memWdata      <= '0;
            r_busOwner      <= 1'b0;
            r_travStartAddr <= '0;
            r_travExecute   <= 1'b0;
            r_wordsLoaded   <= '0;
            r_done          <= 1'b0;
            r_err           <= ERR_NONE;
`ifdef NOUN_LOADER_READBACK_EN
            r_baseAddr      <= '0;
            r_verifyAddr    <= '0;
            r_checksum      <= '0;
            r_readSum       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (load_start) begin
                        r_addr        <= {1'b0, base_addr};
                        r_rootAddr    <= root_addr;
                        r_wordsLoaded <= '0;
                        r_err         <= ERR_NONE;
                        r_busOwner    <= 1'b1;
                        r_state       <= S_ACCEPT;
`ifdef NOUN_LOADER_READBACK_EN
                        r_baseAddr    <= base_addr;
                        r_checksum    <= '0;
                        r_readSum     <= '0;
`endif
                    end
                end
                S_ACCEPT: begin
                    if (in_valid && w_inReady) begin
                        r_data  <= in_data;
                        r_last  <= in_last;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_overflow) begin
                        r_err      <= ERR_OVF;
                        r_busOwner <= 1'b0;
                        r_state    <= S_ERROR;
                    end else begin
                        r_memFunc  <= FUNC_WRITE;
                        r_memAddr  <= r_addr[ADDR_W-1:0];
                        r_memWdata <= r_data;
`ifdef NOUN_LOADER_READBACK_EN
                        r_checksum <= r_checksum ^ r_data;
`endif
                        r_state    <= S_WAIT_MEM;
                    end
                end
                S_WAIT_MEM: begin
                    if (w_reqDone) begin
                        r_wordsLoaded <= r_wordsLoaded + 1'b1;
                        r_addr        <= r_addr + 1'b1;
                        if (r_last) begin
`ifdef NOUN_LOADER_READBACK_EN
                            r_verifyAddr <= {1'b0, r_baseAddr};
                            r_state      <= S_VERIFY;
`else
                            r_busOwner   <= 1'b0;
                            r_state      <= S_START;
`endif
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end
                end
`ifdef NOUN_LOADER_READBACK_EN
                S_VERIFY: begin
                    if (r_verifyAddr == r_addr) begin
                        r_busOwner <= 1'b0;
                        if (r_readSum != r_checksum) begin
                            r_err   <= ERR_MISMATCH;
                            r_state <= S_ERROR;
                        end else begin
                            r_state <= S_START;
                        end
                    end else begin
                        r_memFunc <= FUNC_READ;
                        r_memAddr <= r_verifyAddr[ADDR_W-1:0];
                        r_state   <= S_VERIFY_WAIT;
                    end
                end
                S_VERIFY_WAIT: begin
                    if (w_reqDone) begin
                        r_readSum    <= r_readSum ^ mem_rdata;
                        r_verifyAddr <= r_verifyAddr + 1'b1;
                        r_state      <= S_VERIFY;
                    end
                end
`endif
                S_START: begin
                    r_travStartAddr <= r_rootAddr;
                    r_travExecute   <= 1'b1;
                    r_state         <= S_RUN;
                end
                S_RUN: begin
                    if (trav_finished) begin
                        r_travExecute <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready        = w_inReady;
    assign mem_func        = r_memFunc;
    assign mem_execute     = w_strobe;
    assign mem_addr        = r_memAddr;
    assign mem_wdata       = r_memWdata;
    assign bus_owner       = r_busOwner;
    assign trav_start_addr = r_travStartAddr;
    assign trav_execute    = r_travExecute;
    assign words_loaded    = r_wordsLoaded;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign err             = r_err;

endmodule
